quad_enc_gen: RTL and testbench
===============================

// Module: quad_enc_gen
// PURPOSE
//  Quadrature encoder generator: the transmit side of the motor-encoder interface.
//  Takes a signed step command and emits a 2-bit A/B Gray sequence on enc at a programmed rate.
//  Its own position counter tracks the 16-bit count the encoder decoder produces.
//  Drives the decoder in HIL benches and the encoder-emulation output on the FPGA.
// PARAMETERS
//  CNT_W    16  width of signed step command and of pos
//  DIV_W    16  width of the rate divider (clk cycles per quadrature step)
//  MIN_DIV  2   floor applied to cmd_div; values below this are clamped up to it
// PORTS
//  clk        in   1      system clock, all logic on posedge
//  reset      in   1      asynchronous, active-high; clears all state
//  cmd_valid  in   1      command offer
//  cmd_ready  out  1      = (state==IDLE); command accepted on cmd_valid&&cmd_ready
//  cmd_steps  in   CNT_W  signed step count; +ve forward, -ve reverse
//  cmd_div    in   DIV_W  clk cycles between successive enc transitions
//  abort      in   1      stop the running command at the next clock edge
//  enc        out  2      quadrature output {A,B}, registered
//  pos        out  CNT_W  running signed position, modulo 2^CNT_W
//  busy       out  1      high while a command is executing
//  done       out  1      one-cycle pulse when a command completes or is aborted
// BEHAVIOUR
//  Reset values: enc=2'b00, pos=0, busy=0, done=0, state=IDLE, so cmd_ready=1.
//  Forward sequence: 00->01->11->10->00. Reverse sequence: 00->10->11->01->00.
//  Exactly one enc bit toggles per step; enc never skips a state.
//  enc and pos are continuous across commands; neither is re-zeroed on accept.
//  FSM states:
//   IDLE -> RUN on accept with cmd_steps!=0. Latch rem=|cmd_steps| (CNT_W bits unsigned).
//     -32768 gives rem=32768. Latch dir=sign bit and div=max(cmd_div,MIN_DIV).
//     Load the timer with div-1.
//   IDLE stays in IDLE on accept with cmd_steps==0; done pulses the next cycle.
//   RUN: the timer decrements each cycle. When it reaches 0:
//     - advance enc one step in dir, pos+=1 (fwd) or -=1 (rev), same edge;
//     - decrement rem and reload the timer with div-1;
//     - if rem was 1, go to IDLE and pulse done in the next cycle.
//   RUN -> IDLE on abort=1. A step scheduled for that same edge is suppressed.
//     done pulses once; enc and pos hold their last values.
//  Latency: accepted at edge T -> first enc change at edge T+div -> subsequent changes every div cycles.
//  busy=1 from edge T through the final step edge; done=1 for the cycle after the final step.
//  done is asserted while in IDLE, so a new command may be accepted in the done cycle.
//  cmd_* are ignored while busy; cmd_div changes mid-run have no effect.
//  pos wraps: 16'h7FFF +1 -> 16'h8000; 16'h0000 -1 -> 16'hFFFF.
//  abort in IDLE has no effect. Reset mid-run returns to reset values immediately.
// STRUCTURE
//  Shared package quad_pkg: STEP_0..STEP_3 (2'b00,01,10,11), quad_next/quad_prev functions.
//  The decoder uses the same package so both ends agree on direction.
//  Sub-module quad_rate_timer: loadable down-counter with a tick output at zero, DIV_W wide.
//  The FSM, rem counter, enc register and pos counter stay in quad_enc_gen.
// TESTING
//  1 Reset, then cmd_steps=+5, div=4 -> enc 01,11,10,00,01 at edges T+4,+8,+12,+16,+20.
//    pos=5, single done pulse.
//  2 cmd_steps=-3, div=2 from enc=01 -> enc 00,10,11. pos decrements by 3. busy drops after the 3rd step.
//  3 cmd_steps=0 -> no enc change; done pulse 1 cycle after accept; cmd_ready stays 1.
//  4 cmd_div=0 -> steps every MIN_DIV=2 cycles.
//    pos=16'h7FFF then +1 step -> pos=16'h8000.
//  5 Assert abort after 2 of 10 steps -> enc/pos frozen after step 2, one done pulse, cmd_ready=1.
//    Assert reset mid-run -> enc=00, pos=0, busy=0.
//  6 Loop back into the encoder decoder with random commands; decoder count == pos every cycle after the decoder's 1-cycle lag.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg
//  Definitions shared by the quadrature encoder generator and the decoder, so that
//  both ends agree on which direction each Gray transition means.
//  STEP_0..STEP_3 : the four {A,B} states
//  quad_next      : one step forward  (00->01->11->10->00)
//  quad_prev      : one step reverse  (00->10->11->01->00)
//  gen_state_t    : generator FSM states
package quad_pkg;

    localparam logic [1:0] STEP_0 = 2'b00;
    localparam logic [1:0] STEP_1 = 2'b01;
    localparam logic [1:0] STEP_2 = 2'b10;
    localparam logic [1:0] STEP_3 = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_t;

    function automatic logic [1:0] quad_next(input logic [1:0] s);
        case (s)
            STEP_0:  return STEP_1;
            STEP_1:  return STEP_3;
            STEP_3:  return STEP_2;
            default: return STEP_0;
        endcase
    endfunction

    function automatic logic [1:0] quad_prev(input logic [1:0] s);
        case (s)
            STEP_0:  return STEP_2;
            STEP_2:  return STEP_3;
            STEP_3:  return STEP_1;
            default: return STEP_0;
        endcase
    endfunction

endpackage

// File: rtl/quad_rate_timer.sv
// quad_rate_timer
//  Loadable down-counter that paces quadrature steps.
//  clk      : system clock
//  reset    : asynchronous active-high clear
//  load     : load count with load_val (takes priority over counting)
//  load_val : value to load (cycles remaining minus one)
//  en       : count down while high; tick is only reported while enabled
//  tick     : high in the cycle the count sits at zero
module quad_rate_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             en,
    output logic             tick
);

    logic [DIV_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - DIV_W'(1);
        end
    end

    assign tick = en && (count_reg == '0);

endmodule

// File: rtl/quad_enc_gen.sv
// quad_enc_gen
//  Quadrature encoder generator. Accepts a signed step command and emits that many
//  A/B Gray steps on enc, one every div clock cycles, while tracking position.
//  clk       : system clock
//  reset     : asynchronous active-high clear
//  cmd_valid : command offer; accepted when cmd_ready is also high
//  cmd_ready : high while idle
//  cmd_steps : signed step count (+ forward, - reverse)
//  cmd_div   : clock cycles per step, clamped up to MIN_DIV
//  abort     : stop a running command at the next edge
//  enc       : {A,B} quadrature output
//  pos       : signed running position, wraps modulo 2^CNT_W
//  busy      : high while a command is executing
//  done      : one-cycle pulse after a command completes or is aborted
module quad_enc_gen
    import quad_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int DIV_W   = 16,
    parameter int MIN_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic [1:0]       enc,
    output logic [CNT_W-1:0] pos,
    output logic             busy,
    output logic             done
);

    gen_state_t       state_reg, state_next;
    logic [CNT_W-1:0] rem_reg;
    logic             dir_reg;      // 1 = reverse
    logic [DIV_W-1:0] div_reg;
    logic [1:0]       enc_reg;
    logic [CNT_W-1:0] pos_reg;
    logic             done_reg;

    logic             running;
    logic             accept;
    logic             cmd_zero;
    logic [CNT_W-1:0] cmd_abs;
    logic [DIV_W-1:0] div_clamped;
    logic             tick;
    logic             step;
    logic             last_step;
    logic             timer_load;
    logic [DIV_W-1:0] timer_val;

    assign running  = (state_reg == ST_RUN);
    assign accept   = cmd_valid && cmd_ready;
    assign cmd_zero = (cmd_steps == '0);
    // Unsigned magnitude: the most negative command maps to 2^(CNT_W-1).
    assign cmd_abs  = cmd_steps[CNT_W-1] ? (CNT_W'(0) - cmd_steps) : cmd_steps;
    assign div_clamped = (cmd_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cmd_div;

    // abort wins over a step due on the same edge.
    assign step      = running && tick && !abort;
    assign last_step = step && (rem_reg == CNT_W'(1));

    // Only one of these can occur per cycle: accept needs IDLE, step needs RUN.
    assign timer_load = (accept && !cmd_zero) || step;
    assign timer_val  = accept ? (div_clamped - DIV_W'(1)) : (div_reg - DIV_W'(1));

    quad_rate_timer #(
        .DIV_W(DIV_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (running),
        .tick     (tick)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept && !cmd_zero) state_next = ST_RUN;
            ST_RUN:  if (abort || last_step)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cmd_ready = (state_reg == ST_IDLE);
        busy      = (state_reg == ST_RUN);
    end

    // Command latch, step datapath and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_reg  <= '0;
            dir_reg  <= 1'b0;
            div_reg  <= '0;
            enc_reg  <= STEP_0;
            pos_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            if (accept && !cmd_zero) begin
                rem_reg <= cmd_abs;
                dir_reg <= cmd_steps[CNT_W-1];
                div_reg <= div_clamped;
            end else if (step) begin
                rem_reg <= rem_reg - CNT_W'(1);
                enc_reg <= dir_reg ? quad_prev(enc_reg) : quad_next(enc_reg);
                pos_reg <= dir_reg ? (pos_reg - CNT_W'(1)) : (pos_reg + CNT_W'(1));
            end
            done_reg <= (accept && cmd_zero) || (running && abort) || last_step;
        end
    end

    assign enc  = enc_reg;
    assign pos  = pos_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_quad_enc_gen.sv
module tb_quad_enc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic [15:0] cmd_div;
    logic        abort;
    logic [1:0]  enc;
    logic [15:0] pos;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    quad_enc_gen dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_div   (cmd_div),
        .abort     (abort),
        .enc       (enc),
        .pos       (pos),
        .busy      (busy),
        .done      (done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [1:0]  enc;
        logic [15:0] pos;
    } exp_t;
    exp_t sb[$];

    // Reference Gray tables, indexed by current {A,B}
    logic [1:0] fwd_tbl [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
    logic [1:0] rev_tbl [4] = '{2'b10, 2'b00, 2'b11, 2'b01};

    logic [1:0]  m_enc;
    logic [15:0] m_pos;

    bit          mon_en = 0;
    bit          dec_en = 0;
    logic [1:0]  prev_enc;
    logic [15:0] prev_pos;
    logic [1:0]  dec_enc;
    logic [15:0] dec_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
        end
    endtask

    task automatic pop_check(input bit is_done);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_%s at cycle %0d: got enc=%b pos=%h, expected no event",
                     is_done ? "done" : "step", cyc, enc, pos);
        end else begin
            e = sb.pop_front();
            chk(is_done ? "kind_done" : "kind_step", 32'(is_done), 32'(e.is_done));
            chk("event_cycle", cyc, e.cyc);
            chk("enc", 32'(enc), 32'(e.enc));
            chk("pos", 32'(pos), 32'(e.pos));
        end
    endtask

    // Decoder loopback: counts enc transitions one cycle behind.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_enc <= 2'b00;
            dec_cnt <= 16'h0000;
        end else begin
            dec_enc <= enc;
            if (enc == fwd_tbl[dec_enc])      dec_cnt <= dec_cnt + 16'd1;
            else if (enc == rev_tbl[dec_enc]) dec_cnt <= dec_cnt - 16'd1;
        end
    end

    // Monitor: every enc/pos change and every done pulse consumes one expected event.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (enc !== prev_enc || pos !== prev_pos) begin
                chk("one_bit_toggle", $countones(enc ^ prev_enc), 1);
                pop_check(1'b0);
            end
            if (done) pop_check(1'b1);
            if (dec_en) chk("decoder_vs_pos", 32'(dec_cnt), 32'(prev_pos));
        end
        prev_enc = enc;
        prev_pos = pos;
    end

    task automatic issue(input logic [15:0] steps, input logic [15:0] div_in);
        int t, d, n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_steps = steps;
        cmd_div   = div_in;
        t = cyc + 1;
        chk("ready_before_accept", 32'(cmd_ready), 1);
        d = (div_in < 16'd2) ? 2 : int'(div_in);
        n = steps[15] ? (65536 - int'(steps)) : int'(steps);
        for (int k = 1; k <= n; k++) begin
            m_enc = steps[15] ? rev_tbl[m_enc] : fwd_tbl[m_enc];
            m_pos = steps[15] ? (m_pos - 16'd1) : (m_pos + 16'd1);
            sb.push_back('{1'b0, t + k * d, m_enc, m_pos});
        end
        sb.push_back('{1'b1, t + n * d, m_enc, m_pos});
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'(n != 0));
        chk("ready_after_accept", 32'(cmd_ready), 32'(n == 0));
        // A competing command while busy must be ignored.
        if (n * d >= 4) begin
            cmd_valid = 1'b1;
            cmd_steps = 16'd7;
            cmd_div   = 16'd1;
            @(negedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        for (int i = 0; i < n * d + 10 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_events", sb.size(), 0);
        sb.delete();
    endtask

    task automatic pulse_reset();
        mon_en = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_enc = 2'b00;
        m_pos = 16'h0000;
        @(negedge clk);
        mon_en = 1;
    endtask

    initial begin
        int t;
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_steps = '0;
        cmd_div = '0;
        abort = 1'b0;
        m_enc = 2'b00;
        m_pos = 16'h0000;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_enc", 32'(enc), 0);
        chk("reset_pos", 32'(pos), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        mon_en = 1;

        // 1: +5 steps every 4 cycles -> 01,11,10,00,01
        issue(16'd5, 16'd4);
        chk("t1_enc", 32'(enc), 32'(2'b01));
        chk("t1_pos", 32'(pos), 5);

        // 2: -3 steps every 2 cycles -> 00,10,11
        issue(16'hFFFD, 16'd2);
        chk("t2_enc", 32'(enc), 32'(2'b11));
        chk("t2_pos", 32'(pos), 2);
        chk("t2_busy", 32'(busy), 0);

        // 3: zero steps -> done only
        issue(16'd0, 16'd5);
        chk("t3_ready", 32'(cmd_ready), 1);
        chk("t3_pos", 32'(pos), 2);

        // abort in IDLE does nothing
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_ready", 32'(cmd_ready), 1);

        // 5: abort on the edge that would take step 3 of 10
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_steps = 16'd10;
        cmd_div   = 16'd3;
        t = cyc + 1;
        for (int k = 1; k <= 2; k++) begin
            m_enc = fwd_tbl[m_enc];
            m_pos = m_pos + 16'd1;
            sb.push_back('{1'b0, t + 3 * k, m_enc, m_pos});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        abort = 1'b1;
        sb.push_back('{1'b1, t + 9, m_enc, m_pos});
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready", 32'(cmd_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        repeat (10) @(negedge clk);
        chk("abort_drain", sb.size(), 0);
        chk("abort_pos", 32'(pos), 4);
        sb.delete();

        // Reset in the middle of a run
        mon_en = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_steps = 16'd20;
        cmd_div   = 16'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrun_reset_enc", 32'(enc), 0);
        chk("midrun_reset_pos", 32'(pos), 0);
        chk("midrun_reset_busy", 32'(busy), 0);
        chk("midrun_reset_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_enc = 2'b00;
        m_pos = 16'h0000;
        @(negedge clk);
        mon_en = 1;
        dec_en = 1;

        // Downward wrap: 0 - 1 -> FFFF
        issue(16'hFFFF, 16'd2);
        chk("wrap_down_pos", 32'(pos), 32'hFFFF);
        chk("wrap_down_enc", 32'(enc), 32'(2'b10));
        issue(16'd1, 16'd3);

        // 6: random commands with the decoder loopback active
        for (int i = 0; i < 6; i++) begin
            issue(16'($signed($urandom_range(0, 12)) - 6), 16'($urandom_range(0, 5)));
        end

        // 4: div=0 clamps to 2; climb to 7FFF, then one step to 8000
        pulse_reset();
        issue(16'h7FFF, 16'd0);
        chk("t4_pos_max", 32'(pos), 32'h7FFF);
        chk("t4_enc_max", 32'(enc), 32'(2'b10));
        issue(16'd1, 16'd1);
        chk("t4_pos_wrap", 32'(pos), 32'h8000);
        chk("t4_enc_wrap", 32'(enc), 32'(2'b00));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
